// File: rtl/garegga_pal_pkg.sv
// Shared types and constants for the Garegga palette arbiter.
// Holds the FSM state enum, default widths and RGB555 field positions.
package garegga_pal_pkg;

    localparam int PAL_AW_DEF  = 11;
    localparam int PAL_DW_DEF  = 16;

    localparam int R_LSB       = 0;
    localparam int G_LSB       = 5;
    localparam int B_LSB       = 10;

    // Minimum CLK96 cycles between pixel strobes.
    localparam int PIX_SPACING = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VID_ADDR,
        S_VID_DATA,
        S_CPU_ADDR,
        S_CPU_DATA,
        S_CPU_WR
    } pal_state_e;

endpackage

// File: rtl/garegga_pal_arb.sv
// Palette RAM arbiter: video lookups always win, CPU req/ack fills gaps.
// Macro GAREGGA_PAL_BLANK_ONLY_EN: grant CPU only while display is blanked.
module garegga_pal_arb
    import garegga_pal_pkg::*;
#(
    parameter int PAL_AW = PAL_AW_DEF,
    parameter int PAL_DW = PAL_DW_DEF
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              PIXEL_CEN,
    input  logic              ACTIVE,
    input  logic [PAL_AW-1:0] PIXEL_IDX,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [PAL_AW-1:0] CPU_ADDR,
    input  logic [PAL_DW-1:0] CPU_DIN,
    output logic [PAL_DW-1:0] CPU_DOUT,
    output logic              CPU_ACK,
    output logic [PAL_AW-1:0] PAL_ADDR,
    output logic              PAL_WE,
    output logic [PAL_DW-1:0] PAL_WDATA,
    input  logic [PAL_DW-1:0] PAL_RDATA,
    output logic [4:0]        RED,
    output logic [4:0]        GREEN,
    output logic [4:0]        BLUE,
    output logic              OVERRUN
);

    pal_state_e        state;
    pal_state_e        state_nx;
    logic              vid_pend;
    logic [PAL_AW-1:0] slot_idx;
    logic              slot_act;
    logic              cur_act;
    logic              cpu_ok;
    logic              vid_take;

`ifdef GAREGGA_PAL_BLANK_ONLY_EN
    assign cpu_ok = !slot_act;
`else
    assign cpu_ok = 1'b1;
`endif

    // The pending slot is consumed on the edge IDLE moves to VID_ADDR.
    assign vid_take = (state == S_IDLE) && vid_pend;

    // State register.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next state: video first; a strobe this cycle also holds off the CPU.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (vid_pend)
                    state_nx = S_VID_ADDR;
                else if (!PIXEL_CEN && CPU_REQ && !CPU_ACK && cpu_ok)
                    state_nx = CPU_WE ? S_CPU_WR : S_CPU_ADDR;
            end
            S_VID_ADDR: state_nx = S_VID_DATA;
            S_VID_DATA: state_nx = S_IDLE;
            S_CPU_ADDR: state_nx = S_CPU_DATA;
            S_CPU_DATA: state_nx = S_IDLE;
            S_CPU_WR:   state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Pixel strobe capture into the pending slot, with sticky overrun.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            vid_pend <= 1'b0;
            slot_idx <= '0;
            slot_act <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            if (vid_take)
                vid_pend <= 1'b0;
            if (PIXEL_CEN) begin
                vid_pend <= 1'b1;
                slot_idx <= PIXEL_IDX;
                slot_act <= ACTIVE;
                if (vid_pend && !vid_take)
                    OVERRUN <= 1'b1;
            end
        end
    end

    // RAM port, CPU handshake and colour capture registers.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            PAL_ADDR  <= '0;
            PAL_WE    <= 1'b0;
            PAL_WDATA <= '0;
            CPU_DOUT  <= '0;
            CPU_ACK   <= 1'b0;
            cur_act   <= 1'b0;
            RED       <= '0;
            GREEN     <= '0;
            BLUE      <= '0;
        end else begin
            PAL_WE  <= 1'b0;
            CPU_ACK <= 1'b0;
            case (state_nx)
                S_VID_ADDR: begin
                    PAL_ADDR <= slot_idx;
                    cur_act  <= slot_act;
                end
                S_CPU_ADDR: PAL_ADDR <= CPU_ADDR;
                S_CPU_WR: begin
                    PAL_ADDR  <= CPU_ADDR;
                    PAL_WE    <= 1'b1;
                    PAL_WDATA <= CPU_DIN;
                    CPU_ACK   <= 1'b1;
                end
                default: ;
            endcase
            case (state)
                S_VID_DATA: begin
                    RED   <= cur_act ? PAL_RDATA[R_LSB +: 5] : 5'd0;
                    GREEN <= cur_act ? PAL_RDATA[G_LSB +: 5] : 5'd0;
                    BLUE  <= cur_act ? PAL_RDATA[B_LSB +: 5] : 5'd0;
                end
                S_CPU_DATA: begin
                    CPU_DOUT <= PAL_RDATA;
                    CPU_ACK  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
